control_fsm: RTL
================

// Module: control_fsm
// PURPOSE
//  Multicycle control unit: fetches, decodes and sequences every instruction by driving the datapath control strobes.
//  Consumes the latched instruction word, Z/N flags, irq and memory read_valid; produces one strobe set per state.
//  Also owns interrupt entry/exit (push PC+SR, vector via r12) and HALT. Sits directly upstream of the datapath.
// PARAMETERS
//  MEM_WAIT_MAX  15    max cycles waiting for mem_rvalid before bus_error + HALT (4-bit counter)
//  HALT_OPCODE   4'hF  opcode that enters HALT
// PORTS
//  clock                  in   1   system clock, all state on posedge
//  reset                  in   1   asynchronous, active-low
//  instr                  in   16  current instruction word (opcode [15:12], cond [7:4])
//  z_flag, n_flag         in   1   SR[1], SR[2]
//  irq                    in   1   level interrupt request (key|vga)
//  mem_rvalid             in   1   memory read data valid this cycle
//  reg_write, mem_to_reg, mem_read_is_pc, mem_read_is_sp  out 1  datapath strobes
//  alu_override_imm8, alu_override_imm4, alu_set_flags    out 1  datapath strobes
//  set_pc, pc_from_register, pc_from_irq, pc_from_mem     out 1  datapath strobes
//  sr_from_mem, mem_write, set_sp, increase_sp, reset_irq out 1  datapath strobes
//  mem_write_addr_source  out  1   0=register_data(r1) 1=sp
//  mem_write_data_source  out  2   0=register_data(r2) 1=next_pc 2=this_pc 3=sr
//  halted, bus_error      out  1   status (sticky until reset)
// BEHAVIOUR
//  Reset: state=FETCH, all outputs 0, in_isr=0, wait counter=0; reset mid-instruction aborts with no write.
//  Strobes are Moore outputs of state (+instr decode); every output not listed for a state is 0.
//  FETCH: if irq & ~in_isr -> IRQ_PC. Else mem_read_is_pc=1; on mem_rvalid: set_pc=1 -> EXEC.
//   Counter increments per cycle without rvalid; reaching MEM_WAIT_MAX -> bus_error=1, HALT.
//  EXEC (1 cycle unless noted), by opcode:
//   0 ALU rr : alu_set_flags, reg_write                          -> FETCH
//   1 ALU imm: alu_override_imm4, alu_set_flags, reg_write       -> FETCH
//   2 LDI    : alu_override_imm8, reg_write (flags untouched)    -> FETCH
//   3 LOAD   : -> LOAD_W; LOAD_W holds mem_to_reg, waits mem_rvalid then reg_write -> FETCH
//   4 STORE  : mem_write, addr_src=0, data_src=0                 -> FETCH
//   5 JMP    : cond 0=always 1=Z 2=~Z 3=N 4=~N, 5..F=never; taken -> set_pc, pc_from_register
//   6 CALL   : mem_write addr=sp data=this_pc (PC already +1), set_sp dec, set_pc pc_from_register
//   7 RET    : set_sp+increase_sp -> POP_PC (mem_read_is_sp, wait rvalid; set_pc pc_from_mem)
//   8 PUSH   : mem_write addr=sp data=reg, set_sp dec
//   9 POP    : set_sp+increase_sp -> LOAD_W variant with mem_read_is_sp
//   A RETI   : set_sp+increase_sp -> POP_SR (sr_from_mem on rvalid) -> inc SP -> POP_PC; in_isr<=0
//   F HALT   : -> HALT; B..E: NOP -> FETCH
//  Stack: push = write mem[SP] then SP-1; pop = SP+1 then read mem[SP]; SP arithmetic 16-bit wrap.
//  IRQ entry: IRQ_PC push this_pc; IRQ_SR push sr; IRQ_VEC pc_from_irq+pc_from_register+set_pc,
//   reset_irq=1 for exactly one cycle, in_isr<=1 -> FETCH. irq ignored while in_isr (no nesting).
//  irq is sampled only in FETCH before a fetch starts; never interrupts a multi-cycle instruction.
//  All rvalid waits share the MEM_WAIT_MAX timeout -> bus_error, HALT.
//  HALT: all strobes 0, halted=1, irq ignored; exit only by reset.
// TESTING
//  Fetch rvalid after 2 cycles, instr=0x2105 -> set_pc once, then alu_override_imm8+reg_write, back to FETCH.
//  JMP cond=1 (0x5110) with Z=0 -> no set_pc in EXEC; Z=1 -> set_pc & pc_from_register high 1 cycle.
//  CALL then RET, SP=0x8000 -> mem write @0x8000 data_src=2, SP 0x7FFF; RET pops @0x8000, pc_from_mem.
//  irq=1 in FETCH -> 4 states, writes @SP (this_pc) and SP-1 (sr), reset_irq 1 cycle; 2nd irq ignored until RETI.
//  mem_rvalid held 0 in FETCH -> bus_error=1, halted=1 after 15 cycles; irq has no effect afterward.
//  Reset asserted during LOAD_W -> outputs 0 immediately (async); first cycle after release is FETCH.

Source files
------------

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multicycle control unit: fetch, decode, stack, interrupt entry/exit and HALT sequencing.
// Strobes decode from state (+instr); halted/bus_error are registered and sticky.
module control_fsm #(
  parameter logic [3:0] MEM_WAIT_MAX = 4'd15,
  parameter logic [3:0] HALT_OPCODE  = 4'hF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        z_flag,
  input  logic        n_flag,
  input  logic        irq,
  input  logic        mem_rvalid,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        mem_read_is_pc,
  output logic        mem_read_is_sp,
  output logic        alu_override_imm8,
  output logic        alu_override_imm4,
  output logic        alu_set_flags,
  output logic        set_pc,
  output logic        pc_from_register,
  output logic        pc_from_irq,
  output logic        pc_from_mem,
  output logic        sr_from_mem,
  output logic        mem_write,
  output logic        set_sp,
  output logic        increase_sp,
  output logic        reset_irq,
  output logic        mem_write_addr_source,
  output logic [1:0]  mem_write_data_source,
  output logic        halted,
  output logic        bus_error
);

  typedef enum logic [3:0] {
    S_FETCH, S_EXEC, S_LOAD_W, S_POP_W, S_POP_SR, S_RETI_INC,
    S_POP_PC, S_IRQ_PC, S_IRQ_SR, S_IRQ_VEC, S_HALT
  } state_t;

  state_t     r_state;
  logic [3:0] r_wait;
  logic       r_in_isr;
  logic       r_halted;
  logic       r_bus_error;

  logic [3:0] w_op;
  logic [3:0] w_cond;
  logic       w_taken;
  logic       w_take_irq;
  logic       w_wait_state;
  logic       w_timeout;
  logic       w_unused;

  assign w_op     = instr[15:12];
  assign w_cond   = instr[7:4];
  assign w_unused = ^{instr[11:8], instr[3:0]};

  // irq is only honoured before a fetch has started waiting
  assign w_take_irq   = (r_state == S_FETCH) && (r_wait == 4'd0) && irq && !r_in_isr;
  assign w_wait_state = ((r_state == S_FETCH) && !w_take_irq) || (r_state == S_LOAD_W) ||
                        (r_state == S_POP_W) || (r_state == S_POP_SR) || (r_state == S_POP_PC);
  assign w_timeout    = w_wait_state && !mem_rvalid && (r_wait == MEM_WAIT_MAX - 4'd1);

  always_comb begin
    case (w_cond)
      4'd0:    w_taken = 1'b1;
      4'd1:    w_taken = z_flag;
      4'd2:    w_taken = !z_flag;
      4'd3:    w_taken = n_flag;
      4'd4:    w_taken = !n_flag;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_FETCH;
      r_wait      <= 4'd0;
      r_in_isr    <= 1'b0;
      r_halted    <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      r_wait <= (w_wait_state && !mem_rvalid) ? r_wait + 4'd1 : 4'd0;
      case (r_state)
        S_FETCH: begin
          if (w_take_irq)      r_state <= S_IRQ_PC;
          else if (mem_rvalid) r_state <= S_EXEC;
        end
        S_EXEC: begin
          case (w_op)
            4'h3:        r_state <= S_LOAD_W;
            4'h7:        r_state <= S_POP_PC;
            4'h9:        r_state <= S_POP_W;
            4'hA:        r_state <= S_POP_SR;
            HALT_OPCODE: begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
            default:     r_state <= S_FETCH;
          endcase
        end
        S_LOAD_W, S_POP_W: if (mem_rvalid) r_state <= S_FETCH;
        S_POP_SR:          if (mem_rvalid) r_state <= S_RETI_INC;
        S_RETI_INC: begin
          r_state  <= S_POP_PC;
          r_in_isr <= 1'b0;
        end
        S_POP_PC:          if (mem_rvalid) r_state <= S_FETCH;
        S_IRQ_PC:          r_state <= S_IRQ_SR;
        S_IRQ_SR:          r_state <= S_IRQ_VEC;
        S_IRQ_VEC: begin
          r_state  <= S_FETCH;
          r_in_isr <= 1'b1;
        end
        S_HALT:            r_state <= S_HALT;
        default:           r_state <= S_FETCH;
      endcase
      if (w_timeout) begin
        r_state     <= S_HALT;
        r_wait      <= 4'd0;
        r_halted    <= 1'b1;
        r_bus_error <= 1'b1;
      end
    end
  end

  assign halted    = r_halted;
  assign bus_error = r_bus_error;

  // Gated by reset so an asserted reset silences the datapath without waiting for a clock
  always_comb begin
    reg_write = 1'b0; mem_to_reg = 1'b0; mem_read_is_pc = 1'b0; mem_read_is_sp = 1'b0;
    alu_override_imm8 = 1'b0; alu_override_imm4 = 1'b0; alu_set_flags = 1'b0;
    set_pc = 1'b0; pc_from_register = 1'b0; pc_from_irq = 1'b0; pc_from_mem = 1'b0;
    sr_from_mem = 1'b0; mem_write = 1'b0; set_sp = 1'b0; increase_sp = 1'b0; reset_irq = 1'b0;
    mem_write_addr_source = 1'b0; mem_write_data_source = 2'd0;
    if (reset) begin
      case (r_state)
        S_FETCH: if (!w_take_irq) begin
          mem_read_is_pc = 1'b1;
          set_pc         = mem_rvalid;
        end
        S_EXEC: begin
          case (w_op)
            4'h0: begin alu_set_flags = 1'b1; reg_write = 1'b1; end
            4'h1: begin alu_override_imm4 = 1'b1; alu_set_flags = 1'b1; reg_write = 1'b1; end
            4'h2: begin alu_override_imm8 = 1'b1; reg_write = 1'b1; end
            4'h4: mem_write = 1'b1;
            4'h5: begin set_pc = w_taken; pc_from_register = w_taken; end
            4'h6: begin
              mem_write = 1'b1; mem_write_addr_source = 1'b1; mem_write_data_source = 2'd2;
              set_sp = 1'b1; set_pc = 1'b1; pc_from_register = 1'b1;
            end
            4'h7, 4'h9, 4'hA: begin set_sp = 1'b1; increase_sp = 1'b1; end
            4'h8: begin mem_write = 1'b1; mem_write_addr_source = 1'b1; set_sp = 1'b1; end
            default: ;
          endcase
        end
        S_LOAD_W: begin mem_to_reg = 1'b1; reg_write = mem_rvalid; end
        S_POP_W:  begin mem_to_reg = 1'b1; mem_read_is_sp = 1'b1; reg_write = mem_rvalid; end
        S_POP_SR: begin mem_read_is_sp = 1'b1; sr_from_mem = mem_rvalid; end
        S_RETI_INC: begin set_sp = 1'b1; increase_sp = 1'b1; end
        S_POP_PC: begin mem_read_is_sp = 1'b1; set_pc = mem_rvalid; pc_from_mem = mem_rvalid; end
        S_IRQ_PC: begin
          mem_write = 1'b1; mem_write_addr_source = 1'b1; mem_write_data_source = 2'd2; set_sp = 1'b1;
        end
        S_IRQ_SR: begin
          mem_write = 1'b1; mem_write_addr_source = 1'b1; mem_write_data_source = 2'd3; set_sp = 1'b1;
        end
        S_IRQ_VEC: begin pc_from_irq = 1'b1; pc_from_register = 1'b1; set_pc = 1'b1; reset_irq = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule
